id_imm_issue_ctrl: RTL and testbench
====================================

// Module: id_imm_issue_ctrl
// PURPOSE
// - IF/ID stage controller for the RV32IM pipeline: holds one fetched instruction, decodes imm_select for
//   the immediate extender, and issues to ID/EX with a valid/ready handshake.
// - Detects load-use hazards against the load most recently issued to EX and withholds issue until the load
//   data can be forwarded; honours branch/jump flush from EX.
// PARAMETERS
// - STALL_CYCLES  1   bubbles inserted after a load before a dependent instruction may issue (1..7)
// PORTS
// - CLK             in   1   clock, all state changes on rising edge
// - RESET           in   1   synchronous, active-high reset
// - flush           in   1   squash held instruction (branch/jump taken in EX)
// - in_valid        in   1   IF offers in_inst/in_pc
// - in_ready        out  1   controller accepts this cycle
// - in_inst         in   32  fetched instruction
// - in_pc           in   32  its PC
// - out_valid       out  1   ID/EX may take out_* this cycle
// - out_ready       in   1   ID/EX advancing (not stalled)
// - out_inst        out  32  held instruction; also drives immediate extender imm_value
// - out_pc          out  32  held PC
// - out_imm_select  out  3   000 U/R, 001 I/load/JALR, 010 shift-imm, 011 S, 100 B, 101 J
// - out_illegal     out  1   held opcode not recognised
// - out_hazard      out  1   held instruction blocked by load-use
// BEHAVIOUR
// - Reset (RESET=1 at edge): state EMPTY; out_inst/out_pc/ld_rd=0, out_imm_select=000, out_illegal=0,
//   ld_cnt=0; hence out_valid=0, out_hazard=0, in_ready=1 once RESET deasserts. Reset mid-transfer discards all.
// - States: EMPTY (no instr), FULL (instr held). in_fire=in_valid&in_ready; out_fire=out_valid&out_ready.
// - in_ready = ~flush & (EMPTY | out_fire). out_valid = FULL & ~hazard & ~flush. Latency: accept at edge N,
//   out_valid earliest in cycle N+1.
// - EMPTY: in_fire -> FULL, load out_* from inputs + decode. FULL: out_fire&in_fire -> FULL (replace);
//   out_fire&~in_fire -> EMPTY; else hold; all out_* stable while out_valid&~out_ready.
// - flush (highest priority): -> EMPTY next edge, no accept, no issue that cycle; ld_cnt unaffected.
// - Decode (registered with instr), opcode [6:0]: 0110111/0010111/0110011 -> 000; 0010011 funct3 001/101
//   -> 010, else 001; 0000011/1100111 -> 001; 0100011 -> 011; 1100011 -> 100; 1101111 -> 101;
//   any other -> 000 with out_illegal=1 (still issued; downstream traps).
// - Source use: rs1 [19:15] used by 0010011,0000011,1100111,0100011,1100011,0110011; rs2 [24:20] by
//   0100011,1100011,0110011. U/J use none.
// - Load tracker: on out_fire of opcode 0000011 with rd!=0: ld_rd<=rd, ld_cnt<=STALL_CYCLES. Otherwise when
//   out_ready=1 and ld_cnt!=0: ld_cnt<=ld_cnt-1 (bubble entered EX). ld_cnt holds while out_ready=0.
// - hazard = (ld_cnt!=0) & FULL & ((rs1 used & rs1==ld_rd) | (rs2 used & rs2==ld_rd)); x0 never matches.
//   out_hazard = hazard. Back-to-back load->load dependency handled identically.
// CONFIGURATION
// - LOAD_USE_STALL_EN defined: load tracker + hazard as above.
// - Not defined: tracker removed, hazard/out_hazard tied 0, ld_rd/ld_cnt absent; pipeline relies on EX
//   forwarding/external stall. Ports and all other behaviour identical.
// TESTING
// - RESET=1 two edges, in_valid=1 -> out_valid=0, in_ready=1 after release, out_imm_select=000, nothing held.
// - in 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, out_imm_select=001, out_illegal=0.
// - in 0x4030D113 (srai x2,x1,3) -> 010; in 0xFFFFFFFF -> out_illegal=1, out_imm_select=000.
// - EN, STALL_CYCLES=1: issue 0x0000A283 (lw x5,0(x1)) then 0x00128333 (add x6,x5,x1), out_ready=1 -> add
//   held one cycle with out_valid=0/out_hazard=1, issued next cycle; with x0 as rd no stall; macro off: no stall.
// - FULL with out_ready=0 for 3 cycles -> out_* stable, in_ready=0; out_ready=1 with in_valid -> replace, no gap.
// - flush while FULL and in_valid=1 -> in_ready=0, out_valid=0, next cycle EMPTY; next in_valid accepted.

Source files
------------

// File: rtl/id_imm_issue_ctrl.sv
// id_imm_issue_ctrl: IF/ID holding stage with imm_select decode, valid/ready issue and flush.
// Define LOAD_USE_STALL_EN to add the load-use tracker that withholds dependent instructions.
module id_imm_issue_ctrl #(
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [2:0]  out_imm_select,
  output logic        out_illegal,
  output logic        out_hazard
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  typedef enum logic {EMPTY, FULL} state_t;
  state_t      state_q, state_d;
  logic [31:0] inst_q, pc_q;
  logic [2:0]  imm_q, imm_d;
  logic        ill_q, ill_d;
  logic        full, hazard, in_fire, out_fire;
  logic [6:0]  op_in;
  logic [2:0]  f3_in;
  assign op_in = in_inst[6:0];
  assign f3_in = in_inst[14:12];
  always_comb begin
    imm_d = op_in == OP_IMM ? ((f3_in == 3'b001 || f3_in == 3'b101) ? 3'b010 : 3'b001) :
            (op_in == OP_LOAD || op_in == OP_JALR) ? 3'b001 :
            op_in == OP_STORE  ? 3'b011 :
            op_in == OP_BRANCH ? 3'b100 :
            op_in == OP_JAL    ? 3'b101 : 3'b000;
    ill_d = !(op_in inside {OP_LUI, OP_AUIPC, OP_OP, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL});
  end
  assign full      = state_q == FULL;
  assign out_valid = full & ~hazard & ~flush;
  assign out_fire  = out_valid & out_ready;
  assign in_ready  = ~flush & (~full | out_fire);
  assign in_fire   = in_valid & in_ready;
  always_comb begin
    state_d = flush ? EMPTY : in_fire ? FULL : out_fire ? EMPTY : state_q;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= EMPTY;
      inst_q  <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        inst_q <= in_inst;
        pc_q   <= in_pc;
        imm_q  <= imm_d;
        ill_q  <= ill_d;
      end
    end
  end
  assign out_inst       = inst_q;
  assign out_pc         = pc_q;
  assign out_imm_select = imm_q;
  assign out_illegal    = ill_q;
  assign out_hazard     = hazard;
`ifdef LOAD_USE_STALL_EN
  logic [4:0] ld_rd_q;
  logic [2:0] ld_cnt_q;
  logic [6:0] op_q;
  logic       rs1_use, rs2_use;
  assign op_q    = inst_q[6:0];
  assign rs1_use = op_q inside {OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_OP};
  assign rs2_use = op_q inside {OP_STORE, OP_BRANCH, OP_OP};
  // ld_rd is only ever loaded with a non-zero rd, so x0 sources can never match
  assign hazard = (ld_cnt_q != 3'd0) & full &
                  ((rs1_use & (inst_q[19:15] == ld_rd_q)) | (rs2_use & (inst_q[24:20] == ld_rd_q)));
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ld_rd_q  <= '0;
      ld_cnt_q <= '0;
    end else if (out_fire && op_q == OP_LOAD && inst_q[11:7] != 5'd0) begin
      ld_rd_q  <= inst_q[11:7];
      ld_cnt_q <= 3'(STALL_CYCLES);
    end else if (out_ready && ld_cnt_q != 3'd0) begin
      ld_cnt_q <= ld_cnt_q - 3'd1;
    end
  end
`else
  logic unused_stall;
  assign unused_stall = ^STALL_CYCLES;
  assign hazard = 1'b0;
`endif
endmodule

// File: tb/tb_id_imm_issue_ctrl.sv
// tb_id_imm_issue_ctrl: directed stimulus with a queue scoreboard checked by an issue monitor.
module tb_id_imm_issue_ctrl;
  logic        CLK, RESET, flush, in_valid, in_ready, out_valid, out_ready, out_illegal, out_hazard;
  logic [31:0] in_inst, in_pc, out_inst, out_pc;
  logic [2:0]  out_imm_select;
  int          checks = 0, errors = 0;
  typedef struct packed {logic [31:0] inst; logic [31:0] pc; logic [2:0] imm; logic ill;} exp_t;
  exp_t        q[$];
  logic [31:0] tinst [14] = '{32'h00500093, 32'h4030D113, 32'hFFFFFFFF, 32'h123450B7, 32'h00000097,
                              32'h0020A023, 32'h00208463, 32'h008000EF, 32'h000080E7, 32'h00309093,
                              32'h0FF0F093, 32'h00000033, 32'h0000000B, 32'h00002003};
  logic [2:0]  timm [14] = '{3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b011, 3'b100, 3'b101, 3'b001,
                             3'b010, 3'b001, 3'b000, 3'b000, 3'b001};
  logic        till [14] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b0};

  id_imm_issue_ctrl #(.STALL_CYCLES(1)) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_imm_select(out_imm_select),
    .out_illegal(out_illegal), .out_hazard(out_hazard)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input logic [2:0] imm,
                      input logic ill, input logic ov, input logic push);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    if (push) q.push_back('{inst, pc, imm, ill});
    @(negedge CLK);
    chk("send_in_ready", {31'd0, in_ready}, 32'd1);
    chk("send_out_valid", {31'd0, out_valid}, {31'd0, ov});
    cyc();
  endtask

  always @(negedge CLK) begin
    if (!RESET && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue got inst %h pc %h expected no issue", out_inst, out_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("issue_inst", out_inst, e.inst);
        chk("issue_pc", out_pc, e.pc);
        chk("issue_imm", {29'd0, out_imm_select}, {29'd0, e.imm});
        chk("issue_illegal", {31'd0, out_illegal}, {31'd0, e.ill});
      end
    end
  end

  initial begin
    RESET = 1'b1; flush = 1'b0; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h0; out_ready = 1'b1;
    @(negedge CLK);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    RESET = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid2", {31'd0, out_valid}, 32'd0);
    chk("rst_imm", {29'd0, out_imm_select}, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_hazard", {31'd0, out_hazard}, 32'd0);
    chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
    cyc();
    for (int i = 0; i < 14; i++)
      send(tinst[i], 32'h100 + 32'(4 * i), timm[i], till[i], i > 0, 1'b1);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("stream_tail_valid", {31'd0, out_valid}, 32'd1);
    cyc();
    // load-use: lw x5 then add x6,x5,x1
    send(32'h0000A283, 32'h200, 3'b001, 1'b0, 1'b0, 1'b1);
    send(32'h00128333, 32'h204, 3'b000, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge CLK);
`ifdef LOAD_USE_STALL_EN
    chk("lu_stall_valid", {31'd0, out_valid}, 32'd0);
    chk("lu_stall_hazard", {31'd0, out_hazard}, 32'd1);
    cyc();
    @(negedge CLK);
`endif
    chk("lu_issue_valid", {31'd0, out_valid}, 32'd1);
    chk("lu_issue_hazard", {31'd0, out_hazard}, 32'd0);
    chk("lu_issue_inst", out_inst, 32'h00128333);
    cyc();
    send(32'h0000A003, 32'h300, 3'b001, 1'b0, 1'b0, 1'b1);
    send(32'h00100333, 32'h304, 3'b000, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("x0_valid", {31'd0, out_valid}, 32'd1);
    chk("x0_hazard", {31'd0, out_hazard}, 32'd0);
    cyc();
    // backpressure then replace
    send(32'h00208463, 32'h400, 3'b100, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0FF0F093; in_pc = 32'h404;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_inst", out_inst, 32'h00208463);
      chk("bp_pc", out_pc, 32'h400);
      chk("bp_imm", {29'd0, out_imm_select}, 32'd4);
      cyc();
    end
    out_ready = 1'b1;
    q.push_back('{32'h0FF0F093, 32'h404, 3'b001, 1'b0});
    @(negedge CLK);
    chk("rep_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rep_out_valid", {31'd0, out_valid}, 32'd1);
    cyc();
    in_valid = 1'b0;
    @(negedge CLK);
    chk("rep_nogap_valid", {31'd0, out_valid}, 32'd1);
    chk("rep_nogap_inst", out_inst, 32'h0FF0F093);
    cyc();
    // flush squashes held instruction and refuses the offered one
    send(32'h00500093, 32'h500, 3'b001, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    in_valid = 1'b1; in_inst = 32'h4030D113; in_pc = 32'h504;
    @(negedge CLK);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("fl_empty_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_empty_ready", {31'd0, in_ready}, 32'd1);
    cyc();
    send(32'h123450B7, 32'h600, 3'b000, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    @(negedge CLK);
    chk("post_fl_valid", {31'd0, out_valid}, 32'd1);
    chk("post_fl_inst", out_inst, 32'h123450B7);
    cyc();
    repeat (3) cyc();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
